// File: rtl/hex7seg_pkg.sv
// Shared 7-segment glyph table and segment bit positions.
// Glyphs are active-high, ordered a..g at bits 0..6.
package hex7seg_pkg;

    typedef logic [0:6] glyph_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam glyph_t SEG_0     = 7'b1111110;
    localparam glyph_t SEG_1     = 7'b0110000;
    localparam glyph_t SEG_2     = 7'b1101101;
    localparam glyph_t SEG_3     = 7'b1111001;
    localparam glyph_t SEG_4     = 7'b0110011;
    localparam glyph_t SEG_5     = 7'b1011011;
    localparam glyph_t SEG_6     = 7'b1011111;
    localparam glyph_t SEG_7     = 7'b1110000;
    localparam glyph_t SEG_8     = 7'b1111111;
    localparam glyph_t SEG_9     = 7'b1111011;
    localparam glyph_t SEG_A_HEX = 7'b1110111;
    localparam glyph_t SEG_B_HEX = 7'b0011111;
    localparam glyph_t SEG_C_HEX = 7'b1001110;
    localparam glyph_t SEG_D_HEX = 7'b0111101;
    localparam glyph_t SEG_E_HEX = 7'b1001111;
    localparam glyph_t SEG_F_HEX = 7'b1000111;
    localparam glyph_t SEG_BLANK = 7'b0000000;

    function automatic glyph_t nib_to_seg(input logic [3:0] nib);
        glyph_t g;
        unique case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A_HEX;
            4'hB: g = SEG_B_HEX;
            4'hC: g = SEG_C_HEX;
            4'hD: g = SEG_D_HEX;
            4'hE: g = SEG_E_HEX;
            4'hF: g = SEG_F_HEX;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble/dp/blank to seg[0:7] with output polarity.
// Shared by the scanner and the legacy byte decoder.
module hex7seg_decode
    import hex7seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [0:7] seg
);

    logic [0:7] raw;

    always_comb begin
        raw = '0;
        raw[SEG_A:SEG_G] = blank ? SEG_BLANK : nib_to_seg(nib);
        raw[SEG_DP] = dp & ~blank;
        seg = (ACTIVE_LOW != 0) ? ~raw : raw;
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver, double-buffered.
// Optional leading-zero blanking: HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [0:7]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [0:7] SEG_OFF = {8{ACTIVE_LOW != 0}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        {NUM_DIGITS{ACTIVE_LOW != 0}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         disp_data;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [DW-1:0]         pend_data;
    logic [NUM_DIGITS-1:0] pend_dp;

    logic                  tick;
    logic                  wrap;
    logic                  commit;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  blank;
    logic [NUM_DIGITS-1:0] hot;
    logic [0:7]            dec_seg;

    assign tick   = enable && (cnt == CNT_MAX);
    assign wrap   = tick && (idx == IDX_MAX);
    assign commit = !enable || wrap;

    always_comb begin
        cur_nib = disp_data[3:0];
        cur_dp  = disp_dp[0];
        hot     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hot[k] = (idx == IW'(k));
            if (idx == IW'(k)) begin
                cur_nib = disp_data[4*k +: 4];
                cur_dp  = disp_dp[k];
            end
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msnz;

    // Digit 0 can never exceed msnz, so it is never blanked.
    always_comb begin
        msnz = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (disp_data[4*k +: 4] != 4'h0) begin
                msnz = IW'(k);
            end
        end
        blank = (idx > msnz) && !cur_dp;
    end
`else
    assign blank = 1'b0;
`endif

    hex7seg_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .nib  (cur_nib),
        .dp   (cur_dp),
        .blank(blank),
        .seg  (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            if (!enable) begin
                cnt        <= '0;
                idx        <= '0;
                frame_done <= 1'b0;
                seg        <= SEG_OFF;
                an         <= AN_OFF;
            end else begin
                cnt        <= tick ? '0 : cnt + CW'(1);
                frame_done <= wrap;
                seg        <= dec_seg;
                if (tick) begin
                    idx <= wrap ? '0 : idx + IW'(1);
                end
                if (blank) begin
                    an <= AN_OFF;
                end else begin
                    an <= (ACTIVE_LOW != 0) ? ~hot : hot;
                end
            end
            // An incoming load on a commit cycle bypasses the pending buffer.
            if (commit) begin
                pending <= 1'b0;
                if (load) begin
                    disp_data <= data;
                    disp_dp   <= dp_mask;
                end else if (pending) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                end
            end else if (load) begin
                pend_data <= data;
                pend_dp   <= dp_mask;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomised self-checking bench for hex_display_scanner
// against a cycle-phase behavioural model.
module tb_hex_display_scanner;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_mask = '0;
    logic [0:7]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Active-high glyphs, a in the MSB.
    logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    logic [3:0] SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int          phase;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_pflag;
    logic [0:7]  e_seg;
    logic [3:0]  e_an;
    bit          e_fd;
    bit          model_ok = 1'b0;

    hex_display_scanner #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .data      (data),
        .dp_mask   (dp_mask),
        .seg       (seg),
        .an        (an),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Phase = enabled cycles into the current frame (0..R*N-1).
    task automatic model_step();
        int idx;
        int msnz;
        bit wrap;
        bit blank;
        logic [3:0] nib;
        if (!rst_n) begin
            phase = 0; m_disp = '0; m_pend = '0;
            m_disp_dp = '0; m_pend_dp = '0; m_pflag = 0;
            e_seg = 8'hFF; e_an = 4'hF; e_fd = 0;
            model_ok = 1'b1;
            return;
        end
        idx = (phase / R) % N;
        nib = m_disp[idx*4 +: 4];
        blank = 0;
        msnz = 0;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        for (int k = 0; k < N; k++)
            if (m_disp[k*4 +: 4] != 4'h0) msnz = k;
        blank = (idx > msnz) && !m_disp_dp[idx];
`endif
        if (!enable || blank) begin
            e_seg = 8'hFF;
            e_an = 4'hF;
        end else begin
            e_seg = ~{GLYPH[nib], m_disp_dp[idx]};
            e_an = ~(4'b0001 << idx);
        end
        wrap = enable && (phase == R*N - 1);
        if (!enable) begin
            phase = 0;
            e_fd = 0;
        end else begin
            e_fd = wrap;
            phase = (phase + 1) % (R*N);
        end
        if (!enable || wrap) begin
            if (load) begin
                m_disp = data; m_disp_dp = dp_mask;
            end else if (m_pflag) begin
                m_disp = m_pend; m_disp_dp = m_pend_dp;
            end
            m_pflag = 0;
        end else if (load) begin
            m_pend = data; m_pend_dp = dp_mask; m_pflag = 1;
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("seg", seg, e_seg);
            chk("an", an, e_an);
            chk("pending", pending, m_pflag);
            chk("frame_done", frame_done, e_fd);
        end
    end

    task automatic cyc(input bit r, input bit en, input bit ld,
                       input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        rst_n = r; enable = en; load = ld; data = d; dp_mask = m;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 16'h0, 4'h0);
    endtask

    task automatic wait_an(input logic [3:0] pat, input string nm);
        for (int i = 0; i < 40; i++) begin
            if (an == pat) break;
            idle(1);
        end
        chk(nm, an, pat);
    endtask

    task automatic wait_fd(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (frame_done) break;
            idle(1);
        end
        chk(nm, frame_done, 1);
    endtask

    initial begin
        int cnt;
        bit en;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'h0, 4'h0);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_pend", pending, 0);
        chk("rst_fd", frame_done, 0);

        for (int i = 0; i < 16; i++) begin
            idle(1);
            chk("an_seq", an, SEQ[i/4]);
        end
        wait_fd("fd_first");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            cnt++;
            if (frame_done) break;
        end
        chk("frame_period", cnt, 16);

        idle(5);
        cyc(1, 1, 1, 16'h1A3F, 4'b0100);
        chk("pend_set", pending, 1);
        wait_fd("fd_commit");
        chk("pend_clr", pending, 0);
        wait_an(4'b1110, "an_d0");
        chk("d0_F", seg, 8'b0111000_1);
        wait_an(4'b1101, "an_d1");
        chk("d1_3", seg, 8'b0000110_1);
        wait_an(4'b1011, "an_d2");
        chk("d2_A_dp", seg, 8'b0001000_0);
        wait_an(4'b0111, "an_d3");
        chk("d3_1", seg, 8'b1001111_1);

        idle(2);
        cyc(1, 1, 1, 16'h0001, 4'h0);
        idle(2);
        cyc(1, 1, 1, 16'h0002, 4'h0);
        wait_fd("fd_last");
        chk("last_pclr", pending, 0);
        wait_an(4'b1110, "an_last");
        chk("last_2", seg, 8'b0010010_1);

        for (int i = 0; i < 40; i++) begin
            if (phase == R*N - 1) break;
            idle(1);
        end
        cyc(1, 1, 1, 16'h00C5, 4'h0);
        chk("wrap_pend", pending, 0);
        chk("wrap_fd", frame_done, 1);
        idle(1);
        chk("wrap_d0", seg, 8'b0100100_1);

        idle(6);
        cyc(1, 1, 1, 16'h4321, 4'h0);
        chk("dis_pset", pending, 1);
        cyc(1, 0, 0, 16'h0, 4'h0);
        chk("dis_seg", seg, 8'hFF);
        chk("dis_an", an, 4'hF);
        chk("dis_pclr", pending, 0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 16'h0, 4'h0);
        idle(1);
        chk("reen_an", an, 4'b1110);
        chk("reen_d0", seg, 8'b1001111_1);

        cyc(1, 1, 1, 16'h0050, 4'h0);
        wait_fd("fd_lz");
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            if (an == 4'b1011 || an == 4'b0111) cnt++;
        end
        chk("lz_blanked", cnt, 0);
`else
        wait_an(4'b1011, "an_lz2");
        chk("lz_d2_0", seg, 8'b0000001_1);
        wait_an(4'b0111, "an_lz3");
        chk("lz_d3_0", seg, 8'b0000001_1);
`endif

        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) en = !en;
            cyc($urandom_range(0, 399) != 0, en,
                $urandom_range(0, 5) == 0,
                16'($urandom), 4'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
